// File: rtl/bloom_filter_engine.sv
// Bloom-filter engine for a custom-instruction unit: insert/check keys against a bit array
// using up to four multiplicative hashes, with word-at-a-time clear and a response handshake.
module bloom_filter_engine #(
  parameter int unsigned NUM_BITS = 256,
  parameter int unsigned NUM_HASH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_match_o,
  output logic        rsp_err_o,
  output logic [15:0] fill_count_o
);

  localparam int unsigned IDX_W     = $clog2(NUM_BITS);
  localparam int unsigned NUM_WORDS = NUM_BITS / 32;
  localparam int unsigned WORD_W    = $clog2(NUM_WORDS);

  localparam logic [1:0]        HashLast = 2'(NUM_HASH - 1);
  localparam logic [WORD_W-1:0] ClrLast  = WORD_W'(NUM_WORDS - 1);

  localparam logic [1:0] OpInsert = 2'b00;
  localparam logic [1:0] OpCheck  = 2'b01;
  localparam logic [1:0] OpClear  = 2'b10;

  localparam logic [31:0] Seeds [4] = '{32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F};

  typedef enum logic [1:0] {StIdle, StHash, StClear, StResp} state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] bits_q, bits_d;
  logic [31:0]         key_q, key_d;
  logic [1:0]          op_q, op_d;
  logic [1:0]          hash_cnt_q, hash_cnt_d;
  logic [WORD_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                match_q, match_d;
  logic                err_q, err_d;
  logic [15:0]         fill_q, fill_d;

  logic [31:0]         prod;
  logic [IDX_W-1:0]    idx;

  // Index is the top bits of the low 32-bit product word.
  assign prod = key_q * Seeds[hash_cnt_q];
  assign idx  = prod[31 -: IDX_W];

  always_comb begin
    state_d    = state_q;
    bits_d     = bits_q;
    key_d      = key_q;
    op_d       = op_q;
    hash_cnt_d = hash_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    match_d    = match_q;
    err_d      = err_q;
    fill_d     = fill_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          key_d      = cmd_data_i;
          op_d       = cmd_op_i;
          hash_cnt_d = '0;
          clr_cnt_d  = '0;
          err_d      = 1'b0;
          match_d    = 1'b0;
          if (cmd_op_i == OpInsert || cmd_op_i == OpCheck) begin
            match_d = 1'b1;
            state_d = StHash;
          end else if (cmd_op_i == OpClear) begin
            state_d = StClear;
          end else begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StHash: begin
        // Registered array: a repeated index sees the bit set by an earlier hash.
        match_d = match_q & bits_q[idx];
        if (op_q == OpInsert) bits_d[idx] = 1'b1;
        if (hash_cnt_q == HashLast) state_d = StResp;
        else hash_cnt_d = hash_cnt_q + 2'd1;
      end
      StClear: begin
        bits_d[{clr_cnt_q, 5'b0} +: 32] = '0;
        if (clr_cnt_q == ClrLast) begin
          fill_d  = '0;
          state_d = StResp;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
          if (op_q == OpInsert && fill_q != 16'hFFFF) fill_d = fill_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      bits_q     <= '0;
      key_q      <= '0;
      op_q       <= '0;
      hash_cnt_q <= '0;
      clr_cnt_q  <= '0;
      match_q    <= 1'b1;
      err_q      <= 1'b0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      bits_q     <= bits_d;
      key_q      <= key_d;
      op_q       <= op_d;
      hash_cnt_q <= hash_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      match_q    <= match_d;
      err_q      <= err_d;
      fill_q     <= fill_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_match_o  = rsp_valid_o & match_q;
  assign rsp_err_o    = rsp_valid_o & err_q;
  assign fill_count_o = fill_q;

endmodule

// File: tb/tb_bloom_filter_engine.sv
// Directed bench for bloom_filter_engine: a reference bit-array model feeds a queue of expected
// responses that are popped and compared when the engine responds.
module tb_bloom_filter_engine;

  localparam int unsigned NB = 256;
  localparam int unsigned NH = 3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_match;
  logic        rsp_err;
  logic [15:0] fill_count;

  bloom_filter_engine #(.NUM_BITS(NB), .NUM_HASH(NH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_data_i   (cmd_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_match_o  (rsp_match),
    .rsp_err_o    (rsp_err),
    .fill_count_o (fill_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic match;
    logic err;
    int   lat;
  } exp_t;

  exp_t          sb[$];
  logic [NB-1:0] mbits = '0;
  logic [15:0]   mfill = '0;
  int            total = 0;
  int            bad = 0;
  logic [31:0]   seeds [4] = '{32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F};

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hidx(input logic [31:0] key, input int k);
    logic [31:0] p;
    p = key * seeds[k];
    return int'(p[31:24]);
  endfunction

  // Runs one command to completion; the response is held unaccepted for 'hold' cycles.
  task automatic send(input logic [1:0] op, input logic [31:0] key, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    e.err = 1'b0;
    e.match = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        e.match = 1'b1;
        for (int k = 0; k < NH; k++) begin
          e.match = e.match & mbits[hidx(key, k)];
          if (op == 2'b00) mbits[hidx(key, k)] = 1'b1;
        end
        e.lat = NH + 1;
      end
      2'b10: begin
        mbits = '0;
        e.lat = NB / 32 + 1;
      end
      default: begin
        e.err = 1'b1;
        e.lat = 1;
      end
    endcase
    sb.push_back(e);

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = key;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    got = sb.pop_front();
    check("rsp_latency", lat, got.lat);
    check("rsp_match", rsp_match, got.match);
    check("rsp_err", rsp_err, got.err);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_op = 2'b10;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_match", rsp_match, got.match);
      check("hold_err", rsp_err, got.err);
      check("hold_ready_low", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (op == 2'b00 && mfill != 16'hFFFF) mfill = mfill + 16'd1;
    if (op == 2'b10) mfill = '0;
    check("fill_count", fill_count, mfill);
    check("rsp_valid_after_hs", rsp_valid, 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    mbits = '0;
    mfill = '0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_match", rsp_match, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_fill", fill_count, 0);
    check("rst_array", dut.bits_q, '0);

    // Check on an empty filter.
    send(2'b01, 32'h1, 0);
    check("check_array_unchanged", dut.bits_q, '0);

    // Insert then check the same key.
    send(2'b00, 32'h1, 0);
    send(2'b01, 32'h1, 0);
    check("bit158", dut.bits_q[158], 1);
    check("bit133", dut.bits_q[133], 1);
    check("bit194", dut.bits_q[194], 1);
    check("array_after_insert", dut.bits_q, mbits);

    // Key zero hashes every function to index 0.
    do_reset();
    send(2'b00, 32'h0, 0);
    send(2'b00, 32'h0, 0);
    check("key0_bit0", dut.bits_q[0], 1);
    check("key0_array", dut.bits_q, mbits);

    // Several inserts, then clear.
    send(2'b00, 32'h0000_1234, 0);
    send(2'b00, 32'hDEAD_BEEF, 0);
    send(2'b00, 32'hCAFE_F00D, 0);
    send(2'b01, 32'hDEAD_BEEF, 0);
    send(2'b10, 32'h0, 0);
    check("clear_array", dut.bits_q, '0);
    send(2'b01, 32'h1, 0);

    // Backpressure, then reserved opcode.
    send(2'b00, 32'h0000_0055, 5);
    send(2'b11, 32'h0000_0077, 0);
    check("reserved_array", dut.bits_q, mbits);

    // Mixed traffic over a small key space so checks hit.
    for (int i = 0; i < 10; i++) begin
      send(2'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), 0);
    end
    check("mixed_array", dut.bits_q, mbits);

    // Reset during the fourth CLEAR cycle.
    send(2'b00, 32'hABCD_0123, 0);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b0;
    mbits = '0;
    mfill = '0;
    #1;
    check("midclr_array_in_rst", dut.bits_q, '0);
    check("midclr_valid_in_rst", rsp_valid, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) check("midclr_no_rsp", rsp_valid, 0);
    end
    check("midclr_ready", cmd_ready, 1);
    check("midclr_array", dut.bits_q, '0);
    check("midclr_fill", fill_count, 0);
    send(2'b01, 32'hABCD_0123, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
